control_unit: RTL and testbench

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/matrix_pkg.sv | 25 ++
 rtl/control_unit_if.sv | 47 ++++
 rtl/byte_counter.sv | 43 ++++
 rtl/control_unit.sv | 157 +++++++++++++++
 tb/tb_control_unit.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/matrix_pkg.sv
// Shared constants for the matrix-multiply control path.
// Holds the FSM state codes, the default size limits and a helper that turns a
// latched matrix dimension into an element count. The top-level address logic
// imports the same constants.
package matrix_pkg;

  // Largest accepted matrix dimension N.
  localparam int unsigned MAX_SIZE = 3;
  // Bytes transmitted per result element.
  localparam int unsigned RESULT_BYTES_PER_ELEM = 2;

  // FSM state encoding. Codes 3'b110 and 3'b111 are illegal and recover to idle.
  localparam logic [2:0] StIdle       = 3'b000;
  localparam logic [2:0] StRecvSize   = 3'b001;
  localparam logic [2:0] StRecvA      = 3'b010;
  localparam logic [2:0] StRecvB      = 3'b011;
  localparam logic [2:0] StCompute    = 3'b100;
  localparam logic [2:0] StSendResult = 3'b101;

  // Number of elements in an N x N matrix.
  function automatic int unsigned elem_count(input logic [3:0] n);
    return 32'(n) * 32'(n);
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// Handshake bundle between the control unit and its UART / multiplier peers.
// master: the control unit (consumes rx/tx/mult status, drives the strobes).
// slave : the peripheral side (drives status, consumes the strobes).
//   rx_valid/rx_data   received byte strobe and data
//   tx_busy            transmitter busy
//   mult_done          multiplier result stable
//   rx_enable          receiver bytes are being consumed
//   tx_start           one-cycle transmit request
//   mult_start         one-cycle multiply start
//   read_enable_a/b    operand memory read enables
interface control_unit_if;

  logic       rx_valid;
  logic [7:0] rx_data;
  logic       tx_busy;
  logic       mult_done;
  logic       rx_enable;
  logic       tx_start;
  logic       mult_start;
  logic       read_enable_a;
  logic       read_enable_b;

  modport master (
    input  rx_valid,
    input  rx_data,
    input  tx_busy,
    input  mult_done,
    output rx_enable,
    output tx_start,
    output mult_start,
    output read_enable_a,
    output read_enable_b
  );

  modport slave (
    output rx_valid,
    output rx_data,
    output tx_busy,
    output mult_done,
    input  rx_enable,
    input  tx_start,
    input  mult_start,
    input  read_enable_a,
    input  read_enable_b
  );

endinterface

// File: rtl/byte_counter.sv
// Saturating up-counter with synchronous clear and terminal-count compare.
//   clk_i    clock
//   rst_ni   asynchronous active-low reset
//   clr_i    synchronous clear (wins over inc_i)
//   inc_i    increment enable; ignored once the count reaches term_i
//   term_i   terminal value
//   last_o   the next increment reaches term_i
//   done_o   count equals term_i
module byte_counter #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic [Width-1:0] term_i,
  output logic             last_o,
  output logic             done_o
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q < term_i)) begin
      count_d = count_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign last_o = ((count_q + Width'(1)) == term_i);
  assign done_o = (count_q == term_i);

endmodule

// File: rtl/control_unit.sv
// Sequencer for a UART-fed matrix multiplier.
// Receives a size byte N, then N*N bytes of A and N*N bytes of B, starts the
// multiplier, waits for it, then paces RESULT_BYTES_PER_ELEM*N*N result bytes
// out through the transmitter before returning to idle.
//   clk            system clock
//   rst            asynchronous active-low reset
//   bus            handshake bundle (master side)
//   current_state  encoded FSM state
//   matrix_size    latched dimension N
module control_unit #(
  parameter int unsigned MAX_SIZE              = matrix_pkg::MAX_SIZE,
  parameter int unsigned RESULT_BYTES_PER_ELEM = matrix_pkg::RESULT_BYTES_PER_ELEM
) (
  input  logic                  clk,
  input  logic                  rst,
  control_unit_if.master        bus,
  output logic [2:0]            current_state,
  output logic [3:0]            matrix_size
);

  import matrix_pkg::*;

  // Wide enough for the full result byte count at the largest size.
  localparam int unsigned CntW = $clog2(RESULT_BYTES_PER_ELEM * MAX_SIZE * MAX_SIZE + 1);

  logic [2:0]      state_q, state_d;
  logic [3:0]      size_q, size_d;
  logic            tx_start_q;
  logic            mult_start_q;
  logic            tx_start;

  logic            rx_clr, rx_inc, rx_last;
  logic            tx_clr, tx_inc, tx_done;
  logic [CntW-1:0] rx_term, tx_term;

  logic [3:0]      rx_n;
  logic            size_ok;

  logic [3:0]      unused_rx_hi;
  logic            unused_rx_done;
  logic            unused_tx_last;

  assign rx_n         = bus.rx_data[3:0];
  assign unused_rx_hi = bus.rx_data[7:4];
  assign size_ok      = (rx_n != 4'd0) && (32'(rx_n) <= MAX_SIZE);

  assign rx_term = CntW'(elem_count(size_q));
  assign tx_term = CntW'(RESULT_BYTES_PER_ELEM * elem_count(size_q));

  byte_counter #(
    .Width (CntW)
  ) u_rx_cnt (
    .clk_i  (clk),
    .rst_ni (rst),
    .clr_i  (rx_clr),
    .inc_i  (rx_inc),
    .term_i (rx_term),
    .last_o (rx_last),
    .done_o (unused_rx_done)
  );

  byte_counter #(
    .Width (CntW)
  ) u_tx_cnt (
    .clk_i  (clk),
    .rst_ni (rst),
    .clr_i  (tx_clr),
    .inc_i  (tx_inc),
    .term_i (tx_term),
    .last_o (unused_tx_last),
    .done_o (tx_done)
  );

  always_comb begin
    state_d  = state_q;
    size_d   = size_q;
    rx_clr   = 1'b0;
    rx_inc   = 1'b0;
    tx_clr   = 1'b0;
    tx_inc   = 1'b0;
    tx_start = 1'b0;

    case (state_q)
      StIdle: begin
        rx_clr  = 1'b1;
        tx_clr  = 1'b1;
        state_d = StRecvSize;
      end

      StRecvSize: begin
        // Out-of-range sizes are dropped and the previous size is kept.
        if (bus.rx_valid && size_ok) begin
          size_d  = rx_n;
          state_d = StRecvA;
        end
      end

      StRecvA, StRecvB: begin
        if (bus.rx_valid) begin
          rx_inc = 1'b1;
          if (rx_last) begin
            rx_clr  = 1'b1;
            state_d = (state_q == StRecvA) ? StRecvB : StCompute;
          end
        end
      end

      StCompute: begin
        if (bus.mult_done) begin
          state_d = StSendResult;
        end
      end

      StSendResult: begin
        if (!tx_done) begin
          // A gap cycle after every request lets the transmitter raise tx_busy.
          if (!bus.tx_busy && !tx_start_q) begin
            tx_start = 1'b1;
            tx_inc   = 1'b1;
          end
        end else if (!bus.tx_busy) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      size_q       <= 4'd0;
      tx_start_q   <= 1'b0;
      mult_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      size_q       <= size_d;
      tx_start_q   <= tx_start;
      // High only during the first cycle spent in compute.
      mult_start_q <= (state_d == StCompute) && (state_q != StCompute);
    end
  end

  assign bus.rx_enable     = (state_q == StRecvSize) || (state_q == StRecvA) ||
                             (state_q == StRecvB);
  assign bus.read_enable_a = (state_q == StCompute) || (state_q == StSendResult);
  assign bus.read_enable_b = (state_q == StCompute) || (state_q == StSendResult);
  assign bus.tx_start      = tx_start;
  assign bus.mult_start    = mult_start_q;

  assign current_state = state_q;
  assign matrix_size   = size_q;

endmodule

// File: tb/tb_control_unit.sv
module tb_control_unit;

  import matrix_pkg::*;

  logic       clk;
  logic       rst;
  logic [2:0] current_state;
  logic [3:0] matrix_size;

  int checks;
  int errors;

  control_unit_if bus_if ();

  control_unit u_dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus_if),
    .current_state (current_state),
    .matrix_size   (matrix_size)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus_if.rx_valid = 1'b1;
    bus_if.rx_data  = b;
    tick();
    bus_if.rx_valid = 1'b0;
    bus_if.rx_data  = 8'h00;
  endtask

  // Transmitter model: tx_busy rises the cycle after each tx_start and stays high 10 cycles.
  task automatic run_send(input int stop_at, output int pulses, output int busy_hits);
    int busy_left;
    busy_left = 0;
    pulses    = 0;
    busy_hits = 0;
    for (int c = 0; c < 1000; c++) begin
      bus_if.tx_busy = (busy_left > 0);
      if (busy_left > 0) busy_left--;
      #1;
      if (bus_if.tx_start === 1'b1) begin
        pulses++;
        if (bus_if.tx_busy !== 1'b0) busy_hits++;
        busy_left = 10;
      end
      tick();
      if (stop_at > 0 && pulses >= stop_at) break;
      if (current_state !== StSendResult) break;
    end
    bus_if.tx_busy = 1'b0;
  endtask

  task automatic test_reset();
    rst              = 1'b0;
    bus_if.rx_valid  = 1'b0;
    bus_if.rx_data   = 8'h00;
    bus_if.tx_busy   = 1'b0;
    bus_if.mult_done = 1'b0;
    repeat (3) tick();
    checks++;
    if (current_state !== 3'b000) begin
      errors++; $display("FAIL reset_state got %b want 000", current_state);
    end
    checks++;
    if (matrix_size !== 4'd0) begin
      errors++; $display("FAIL reset_size got %0d want 0", matrix_size);
    end
    checks++;
    if ({bus_if.rx_enable, bus_if.tx_start, bus_if.mult_start,
         bus_if.read_enable_a, bus_if.read_enable_b} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs got %b want 00000",
               {bus_if.rx_enable, bus_if.tx_start, bus_if.mult_start,
                bus_if.read_enable_a, bus_if.read_enable_b});
    end
    rst = 1'b1;
    tick();
    checks++;
    if (current_state !== 3'b001) begin
      errors++; $display("FAIL release_state got %b want 001", current_state);
    end
    checks++;
    if (bus_if.rx_enable !== 1'b1) begin
      errors++; $display("FAIL release_rx_enable got %b want 1", bus_if.rx_enable);
    end
    checks++;
    if ({bus_if.tx_start, bus_if.mult_start, bus_if.read_enable_a,
         bus_if.read_enable_b} !== 4'b0) begin
      errors++; $display("FAIL release_outputs got %b want 0000",
                         {bus_if.tx_start, bus_if.mult_start, bus_if.read_enable_a,
                          bus_if.read_enable_b});
    end
  endtask

  task automatic test_size_reject();
    logic [7:0] bad [3];
    bad[0] = 8'h00;
    bad[1] = 8'h05;
    bad[2] = 8'h04;
    for (int i = 0; i < 3; i++) begin
      send_byte(bad[i]);
      checks++;
      if (current_state !== 3'b001 || matrix_size !== 4'd0) begin
        errors++;
        $display("FAIL size_reject_%0d got state %b size %0d want 001 size 0",
                 i, current_state, matrix_size);
      end
    end
    send_byte(8'h02);
    checks++;
    if (current_state !== 3'b010 || matrix_size !== 4'd2) begin
      errors++;
      $display("FAIL size_accept got state %b size %0d want 010 size 2",
               current_state, matrix_size);
    end
    for (int i = 0; i < 4; i++) send_byte(8'h10 + 8'(i));
    checks++;
    if (current_state !== 3'b011) begin
      errors++; $display("FAIL n2_a_done got %b want 011", current_state);
    end
    for (int i = 0; i < 3; i++) send_byte(8'h20 + 8'(i));
    checks++;
    if (current_state !== 3'b011) begin
      errors++; $display("FAIL n2_b_partial got %b want 011", current_state);
    end
    send_byte(8'h23);
    checks++;
    if (current_state !== 3'b100) begin
      errors++; $display("FAIL n2_b_done got %b want 100", current_state);
    end
    checks++;
    if ({bus_if.mult_start, bus_if.read_enable_a, bus_if.read_enable_b,
         bus_if.rx_enable} !== 4'b1110) begin
      errors++; $display("FAIL compute_entry_outputs got %b want 1110",
                         {bus_if.mult_start, bus_if.read_enable_a, bus_if.read_enable_b,
                          bus_if.rx_enable});
    end
  endtask

  task automatic test_rx_ignored();
    tick();
    checks++;
    if (bus_if.mult_start !== 1'b0 || current_state !== 3'b100) begin
      errors++; $display("FAIL mult_start_drop got %b state %b want 0 state 100",
                         bus_if.mult_start, current_state);
    end
    bus_if.rx_valid = 1'b1;
    bus_if.rx_data  = 8'h01;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (current_state !== 3'b100) begin
        errors++; $display("FAIL rx_in_compute_%0d got %b want 100", i, current_state);
      end
    end
    bus_if.rx_valid  = 1'b0;
    bus_if.tx_busy   = 1'b1;
    bus_if.mult_done = 1'b1;
    tick();
    bus_if.mult_done = 1'b0;
    checks++;
    if (current_state !== 3'b101) begin
      errors++; $display("FAIL to_send got %b want 101", current_state);
    end
    bus_if.rx_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (current_state !== 3'b101 || bus_if.tx_start !== 1'b0) begin
        errors++; $display("FAIL rx_in_send_%0d got state %b tx_start %b want 101 0",
                           i, current_state, bus_if.tx_start);
      end
    end
    bus_if.rx_valid = 1'b0;
  endtask

  task automatic test_reset_mid_send();
    int pulses;
    int busy_hits;
    run_send(7, pulses, busy_hits);
    checks++;
    if (pulses !== 7 || current_state !== 3'b101) begin
      errors++; $display("FAIL partial_send got %0d pulses state %b want 7 101",
                         pulses, current_state);
    end
    bus_if.tx_busy = 1'b0;
    rst = 1'b0;
    #1;
    checks++;
    if (current_state !== 3'b000 || bus_if.tx_start !== 1'b0 || matrix_size !== 4'd0 ||
        bus_if.read_enable_a !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got state %b tx_start %b size %0d rd %b want 000 0 0 0",
               current_state, bus_if.tx_start, matrix_size, bus_if.read_enable_a);
    end
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if (current_state !== 3'b001) begin
      errors++; $display("FAIL rerelease_state got %b want 001", current_state);
    end
  endtask

  task automatic test_full_run();
    int ms_count;
    int pulses;
    int busy_hits;
    send_byte(8'h03);
    checks++;
    if (current_state !== 3'b010 || matrix_size !== 4'd3) begin
      errors++; $display("FAIL n3_size got state %b size %0d want 010 3",
                         current_state, matrix_size);
    end
    for (int i = 0; i < 8; i++) send_byte(8'(i));
    checks++;
    if (current_state !== 3'b010) begin
      errors++; $display("FAIL n3_a_partial got %b want 010", current_state);
    end
    send_byte(8'h08);
    checks++;
    if (current_state !== 3'b011) begin
      errors++; $display("FAIL n3_a_done got %b want 011", current_state);
    end
    for (int i = 0; i < 9; i++) send_byte(8'h40 + 8'(i));
    checks++;
    if (current_state !== 3'b100) begin
      errors++; $display("FAIL n3_b_done got %b want 100", current_state);
    end
    ms_count = (bus_if.mult_start === 1'b1) ? 1 : 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus_if.mult_start === 1'b1) ms_count++;
    end
    checks++;
    if (current_state !== 3'b100) begin
      errors++; $display("FAIL compute_wait got %b want 100", current_state);
    end
    bus_if.mult_done = 1'b1;
    tick();
    bus_if.mult_done = 1'b0;
    if (bus_if.mult_start === 1'b1) ms_count++;
    checks++;
    if (ms_count !== 1) begin
      errors++; $display("FAIL mult_start_pulses got %0d want 1", ms_count);
    end
    checks++;
    if (current_state !== 3'b101) begin
      errors++; $display("FAIL n3_send_entry got %b want 101", current_state);
    end
    run_send(0, pulses, busy_hits);
    checks++;
    if (pulses !== 18) begin
      errors++; $display("FAIL tx_pulses got %0d want 18", pulses);
    end
    checks++;
    if (busy_hits !== 0) begin
      errors++; $display("FAIL tx_while_busy got %0d want 0", busy_hits);
    end
    checks++;
    if (current_state !== 3'b000) begin
      errors++; $display("FAIL send_to_idle got %b want 000", current_state);
    end
    tick();
    checks++;
    if (current_state !== 3'b001) begin
      errors++; $display("FAIL idle_to_size got %b want 001", current_state);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_size_reject();
    test_rx_ignored();
    test_reset_mid_send();
    test_full_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
